// File: rtl/bcd_serial_subtractor.sv
// Serial packed-BCD subtractor: D = A - B in ten's complement, one digit/clock.
// Ports: clk, rst, start, A, B -> busy, done, D, Bout (final borrow), err (digit>9).
module bcd_serial_subtractor #(
  parameter int NDIG = 4,
  parameter int CW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] A,
  input  logic [4*NDIG-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] D,
  output logic              Bout,
  output logic              err
);

  localparam int W = 4 * NDIG;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  part;
  logic [W-1:0]  part_nxt;
  logic          bin;
  logic [CW-1:0] idx;
  logic          err_acc;

  logic [5:0]    t;
  logic          bnext;
  logic [3:0]    dig;
  logic          in_err;
  logic          last;

  // Digit slice: operands shift down so the active digit is always at [3:0].
  always_comb begin
    t        = {2'b00, a_sr[3:0]} - {2'b00, b_sr[3:0]} - {5'd0, bin};
    bnext    = t[5];
    dig      = bnext ? (t[3:0] + 4'd10) : t[3:0];
    part_nxt = part;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == CW'(i)) part_nxt[4*i +: 4] = dig;
    end
    in_err = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (A[4*i +: 4] > 4'd9) in_err = 1'b1;
      if (B[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
    last = (idx == CW'(NDIG - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      part    <= '0;
      bin     <= 1'b0;
      idx     <= '0;
      err_acc <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      D       <= '0;
      Bout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= A;
            b_sr    <= B;
            part    <= '0;
            bin     <= 1'b0;
            idx     <= '0;
            err_acc <= in_err;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 4;
          b_sr <= b_sr >> 4;
          bin  <= bnext;
          part <= part_nxt;
          idx  <= idx + CW'(1);
          if (last) begin
            D     <= part_nxt;
            Bout  <= bnext;
            err   <= err_acc;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor: directed and random operands,
// expected results queued at issue time and checked by a done-driven monitor.
module tb_bcd_serial_subtractor;

  localparam int NDIG = 4;
  localparam int CW   = 3;
  localparam int W    = 4 * NDIG;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         er;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t q[$];

  bit   gap_chk = 1'b0;
  int   last_done_cyc = -1;
  int   busy_cnt = 0;
  logic [W-1:0] last_d = '0;

  bcd_serial_subtractor #(.NDIG(NDIG), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal value arithmetic for valid operands; for operands
  // containing non-decimal digits, the digit-wise borrow rule keeping 4 bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    int   av, bv, diff, p, bw, t;
    bit   inval;
    inval = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) inval = 1'b1;
    end
    r.er = inval;
    r.d  = '0;
    if (!inval) begin
      av = 0; bv = 0; p = 1;
      for (int i = 0; i < NDIG; i++) begin
        av += int'(a[4*i +: 4]) * p;
        bv += int'(b[4*i +: 4]) * p;
        p  *= 10;
      end
      diff = av - bv;
      r.bo = (diff < 0);
      if (diff < 0) diff += p;
      for (int i = 0; i < NDIG; i++) begin
        r.d[4*i +: 4] = 4'(diff % 10);
        diff = diff / 10;
      end
    end else begin
      bw = 0;
      for (int i = 0; i < NDIG; i++) begin
        t  = int'(a[4*i +: 4]) - int'(b[4*i +: 4]) - bw;
        bw = (t < 0) ? 1 : 0;
        if (t < 0) t += 10;
        r.d[4*i +: 4] = 4'(t & 15);
      end
      r.bo = bw[0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++) begin
      if (allow_bad && $urandom_range(0, 7) == 0)
        v[4*i +: 4] = 4'($urandom_range(0, 15));
      else
        v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: result checking, busy width, done spacing, D stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_d   = '0;
      busy_cnt = 0;
    end else if (done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("D", D, e.d);
        chk("Bout", W'(Bout), W'(e.bo));
        chk("err", W'(err), W'(e.er));
      end
      chk("busy_width", W'(busy_cnt), W'(NDIG));
      if (gap_chk && last_done_cyc >= 0)
        chk("done_gap", W'(cyc - last_done_cyc), W'(NDIG + 1));
      last_done_cyc = cyc;
      busy_cnt = 0;
      last_d   = D;
    end else begin
      if (busy) busy_cnt++;
      chk("D_stable", D, last_d);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%b expected 0", busy);
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    A = a;
    B = b;
    start = 1'b1;
    q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    A = rand_bcd(1'b1);
    B = rand_bcd(1'b1);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_D", D, '0);
    chk("rst_Bout", W'(Bout), '0);
    chk("rst_err", W'(err), '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(16'h5000, 16'h1234);
    do_op(16'h0123, 16'h0456);
    do_op(16'h0000, 16'h0001);
    do_op(16'h9999, 16'h9999);
    do_op(16'h1000, 16'h0001);
    do_op(16'h00A5, 16'h0003);
    do_op(16'h0005, 16'h0003);
    do_op(16'h0000, 16'h9999);

    // Restart attempt during RUN must be ignored
    do_op(16'h4321, 16'h1111);
    A = 16'h9999;
    B = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Start held high: one result every NDIG+1 cycles
    wait_idle();
    @(negedge clk);
    gap_chk = 1'b1;
    last_done_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      A = rand_bcd(1'b0);
      B = rand_bcd(1'b0);
      start = 1'b1;
      if (busy === 1'b0) q.push_back(model(A, B));
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    gap_chk = 1'b0;

    // Asynchronous reset mid-RUN
    do_op(16'h8765, 16'h1234);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", W'(busy), '0);
    chk("arst_done", W'(done), '0);
    chk("arst_D", D, '0);
    chk("arst_Bout", W'(Bout), '0);
    chk("arst_err", W'(err), '0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_op(16'h2000, 16'h0999);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      ra = rand_bcd(1'b1);
      rb = rand_bcd(1'b1);
      do_op(ra, rb);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
